// File: rtl/ws2812_frame_sequencer.sv
// WS2812 chain refresh sequencer: walks LED frames from the frame mux and
// serialises each 24-bit GRB word MSB-first as NRZ pulses, then holds the latch period.
module ws2812_frame_sequencer #(
  parameter int unsigned N_LEDS  = 8,
  parameter int unsigned T0H_CYC = 20,
  parameter int unsigned T1H_CYC = 40,
  parameter int unsigned BIT_CYC = 62,
  parameter int unsigned RST_CYC = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] frame_in,
  output logic [2:0]  frame_sel,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] BitLast = 16'(BIT_CYC - 1);
  localparam logic [15:0] BitPre  = 16'(BIT_CYC - 2);
  localparam logic [15:0] RstLast = 16'(RST_CYC - 1);
  localparam logic [15:0] T0h     = 16'(T0H_CYC);
  localparam logic [15:0] T1h     = 16'(T1H_CYC);
  localparam logic [2:0]  LedLast = 3'(N_LEDS - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StBit, StLatch} state_e;

  state_e      state_q;
  logic [23:0] shift_q;
  logic [4:0]  bit_q;
  logic [15:0] cyc_q;
  logic [2:0]  led_q;
  logic [15:0] high_len;

  always_comb begin
    high_len = T0h;
    if (shift_q[23]) high_len = T1h;
  end

  // dout is computed from the current bit state, so the line lags the
  // sequencer by one cycle; done and busy are aligned to that line timing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_q     <= '0;
      cyc_q     <= '0;
      led_q     <= '0;
      frame_sel <= '0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      dout <= (state_q == StBit) && (cyc_q < high_len);
      case (state_q)
        StIdle: begin
          cyc_q <= '0;
          bit_q <= '0;
          led_q <= '0;
          // The cycle carrying done still counts as busy, so start is ignored there.
          if (start && !done) begin
            state_q   <= StLoad;
            busy      <= 1'b1;
            frame_sel <= '0;
          end else begin
            busy <= 1'b0;
          end
        end
        StLoad: begin
          shift_q <= frame_in;
          bit_q   <= 5'd23;
          cyc_q   <= '0;
          state_q <= StBit;
        end
        StBit: begin
          if (cyc_q == BitLast) begin
            cyc_q <= '0;
            if (bit_q != 5'd0) begin
              shift_q <= {shift_q[22:0], 1'b0};
              bit_q   <= bit_q - 5'd1;
            end else if (led_q != LedLast) begin
              shift_q <= frame_in;
              bit_q   <= 5'd23;
              led_q   <= led_q + 3'd1;
            end else begin
              state_q <= StLatch;
            end
          end else begin
            cyc_q <= cyc_q + 16'd1;
            // Select the next LED one cycle early so the mux has a full cycle to settle.
            if (bit_q == 5'd0 && cyc_q == BitPre && led_q != LedLast) begin
              frame_sel <= frame_sel + 3'd1;
            end
          end
        end
        StLatch: begin
          if (cyc_q == RstLast) begin
            done      <= 1'b1;
            state_q   <= StIdle;
            frame_sel <= '0;
            led_q     <= '0;
            cyc_q     <= '0;
          end else begin
            cyc_q <= cyc_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: default chain plus a tiny single-LED chain,
// both compared every cycle against a timeline model of the refresh.
module tb_ws2812_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, dout_a, busy_a, done_a;
  logic [23:0] frame_a;
  logic [2:0]  sel_a;
  logic        rst_b, start_b, dout_b, busy_b, done_b;
  logic [23:0] frame_b;
  logic [2:0]  sel_b;

  logic [23:0] fr_a [8];
  logic [23:0] fr_b [8];

  assign frame_a = fr_a[sel_a];
  assign frame_b = fr_b[sel_b];

  ws2812_frame_sequencer dut_a (
    .clk(clk), .rst_n(rst_a), .start(start_a), .frame_in(frame_a),
    .frame_sel(sel_a), .dout(dout_a), .busy(busy_a), .done(done_a)
  );

  ws2812_frame_sequencer #(
    .N_LEDS(1), .T0H_CYC(2), .T1H_CYC(4), .BIT_CYC(6), .RST_CYC(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_b), .start(start_b), .frame_in(frame_b),
    .frame_sel(sel_b), .dout(dout_b), .busy(busy_b), .done(done_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected {frame_sel, dout, busy, done} k cycles after the accepting start edge.
  function automatic logic [5:0] model_out(input int k, input int nleds, input int t0h,
                                           input int t1h, input int bitc, input int rstc,
                                           input logic [23:0] fr [8]);
    int   flen;
    int   len;
    int   t;
    int   led;
    int   bitn;
    int   c;
    int   sel;
    logic d;
    flen = 24 * bitc;
    len  = 2 + nleds * flen + rstc;
    t    = k - 2;
    d    = 1'b0;
    if (t >= 0 && t < nleds * flen) begin
      led  = t / flen;
      bitn = 23 - (t % flen) / bitc;
      c    = t % bitc;
      d    = (c < (fr[led][bitn] ? t1h : t0h));
    end
    if (k < len - 1) begin
      sel = k / flen;
      if (sel > nleds - 1) sel = nleds - 1;
    end else begin
      sel = 0;
    end
    return {3'(sel), d, 1'b1, (k == len - 1)};
  endfunction

  localparam int LenA = 2 + 8 * 24 * 62 + 250;
  localparam int LenB = 2 + 1 * 24 * 6 + 3;

  bit act_a = 0, act_b = 0;
  int k_a = 0, k_b = 0;

  always @(posedge clk) begin
    logic sa, ra, sb, rb;
    logic [5:0] exp_a, exp_b;
    sa = start_a; ra = rst_a; sb = start_b; rb = rst_b;
    if (!ra) act_a = 0;
    else if (act_a) begin k_a++; if (k_a == LenA) act_a = 0; end
    else if (sa) begin act_a = 1; k_a = 0; end
    if (!rb) act_b = 0;
    else if (act_b) begin k_b++; if (k_b == LenB) act_b = 0; end
    else if (sb) begin act_b = 1; k_b = 0; end
    #1;
    exp_a = act_a ? model_out(k_a, 8, 20, 40, 62, 250, fr_a) : 6'd0;
    exp_b = act_b ? model_out(k_b, 1, 2, 4, 6, 3, fr_b) : 6'd0;
    check("a_sel_dout_busy_done", 32'({sel_a, dout_a, busy_a, done_a}), 32'(exp_a));
    check("b_sel_dout_busy_done", 32'({sel_b, dout_b, busy_b, done_b}), 32'(exp_b));
  end

  // Refresh-relative bookkeeping for instance a.
  int       rel = 0;
  int       done_cnt = 0;
  int       done_at = -1;
  logic     prev_dout = 1'b0;
  logic [7:0] rise_ok = '0;
  logic     busy_last = 1'b0, busy_after = 1'b1;

  task automatic begin_refresh();
    rel = 0; done_cnt = 0; done_at = -1; rise_ok = '0; prev_dout = dout_a;
    busy_last = 1'b0; busy_after = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    rel++;
    if (done_a) begin done_cnt++; done_at = rel; end
    if (rel >= 2 && (rel - 2) % 1488 == 0 && (rel - 2) / 1488 < 8)
      rise_ok[(rel - 2) / 1488] = dout_a && !prev_dout;
    if (rel == LenA - 1) busy_last = busy_a;
    if (rel == LenA) busy_after = busy_a;
    prev_dout = dout_a;
  endtask

  task automatic run_to(input int target);
    while (rel < target) step();
  endtask

  task automatic pulse_at(input int target);
    run_to(target - 1);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  initial begin
    logic [23:0] pin [8];
    logic [5:0]  m;
    // Pin the model against hand-computed points.
    pin = '{24'h800001, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    m = model_out(2, 8, 20, 40, 62, 250, pin);    check("pin_a_first_rise", 32'(m[2]), 1);
    m = model_out(41, 8, 20, 40, 62, 250, pin);   check("pin_a_b23_high40", 32'(m[2]), 1);
    m = model_out(42, 8, 20, 40, 62, 250, pin);   check("pin_a_b23_low", 32'(m[2]), 0);
    m = model_out(83, 8, 20, 40, 62, 250, pin);   check("pin_a_b22_high20", 32'(m[2]), 1);
    m = model_out(84, 8, 20, 40, 62, 250, pin);   check("pin_a_b22_low", 32'(m[2]), 0);
    m = model_out(1467, 8, 20, 40, 62, 250, pin); check("pin_a_b0_high40", 32'(m[2]), 1);
    m = model_out(1490, 8, 20, 40, 62, 250, pin); check("pin_a_led1_rise", 32'(m[5:2]), 32'h3);
    m = model_out(12155, 8, 20, 40, 62, 250, pin); check("pin_a_done", 32'(m), 32'h03);
    pin = '{default: 24'hFFFFFF};
    m = model_out(5, 1, 2, 4, 6, 3, pin);   check("pin_b_high4", 32'(m[2]), 1);
    m = model_out(6, 1, 2, 4, 6, 3, pin);   check("pin_b_low", 32'(m[2]), 0);
    m = model_out(148, 1, 2, 4, 6, 3, pin); check("pin_b_done", 32'(m), 32'h03);

    // Reset held with start asserted.
    fr_a = '{24'h800001, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0};
    rst_a = 1'b0; start_a = 1'b1;
    repeat (3) step();
    start_a = 1'b0; rst_a = 1'b1;
    step(); step();

    // Refresh 1 with stray starts at 100, 5000 and the done cycle.
    start_a = 1'b1; step(); start_a = 1'b0;
    begin_refresh();
    pulse_at(100);
    pulse_at(5000);
    pulse_at(12155);
    run_to(12170);
    check("r1_done_count", 32'(done_cnt), 1);
    check("r1_done_cycle", 32'(done_at), 12155);
    check("r1_busy_done_cycle", 32'(busy_last), 1);
    check("r1_busy_after_done", 32'(busy_after), 0);
    for (int k = 0; k < 8; k++) check($sformatf("r1_led%0d_rise", k), 32'(rise_ok[k]), 1);

    // Refresh 2 aborted by reset at cycle 3000.
    start_a = 1'b1; step(); start_a = 1'b0;
    begin_refresh();
    run_to(2999);
    rst_a = 1'b0; step();
    check("abort_dout", 32'(dout_a), 0);
    check("abort_busy", 32'(busy_a), 0);
    rst_a = 1'b1;
    for (int i = 0; i < 8; i++) fr_a[i] = 24'($urandom);
    step();

    // Refresh 3 with random frames after the abort.
    start_a = 1'b1; step(); start_a = 1'b0;
    begin_refresh();
    run_to(12165);
    check("r3_done_count", 32'(done_cnt), 1);
    check("r3_done_cycle", 32'(done_at), 12155);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Tiny chain: one all-ones refresh, then random starts, resets and frames.
  initial begin
    fr_b = '{default: 24'hFFFFFF};
    rst_b = 1'b0; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_b = 1'b1; start_b = 1'b1;
    @(posedge clk);
    #2 start_b = 1'b0;
    repeat (160) @(posedge clk);
    forever begin
      @(posedge clk);
      #2;
      start_b = ($urandom_range(0, 29) == 0);
      rst_b   = ($urandom_range(0, 399) != 0);
      if (!act_b) fr_b[0] = 24'($urandom);
    end
  end

endmodule
